// File: rtl/dmem_write_monitor_if.sv
// Write-tap and drain-port signal bundle for dmem_write_monitor.
// The monitor takes the slave side; the CPU tap and the consumer together form the master side.
interface dmem_write_monitor_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32
);
  logic              We;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              OutValid;
  logic              OutReady;
  logic [TS_W-1:0]   OutTs;
  logic [ADDR_W-1:0] OutAddr;
  logic [DATA_W-1:0] OutData;

  modport master (
    output We, WrAddr, WrData, OutReady,
    input  OutValid, OutTs, OutAddr, OutData
  );

  modport slave (
    input  We, WrAddr, WrData, OutReady,
    output OutValid, OutTs, OutAddr, OutData
  );
endinterface

// File: rtl/dmem_write_monitor.sv
// Timestamps data-memory writes inside an address window and queues them in a FIFO
// that a consumer drains over a valid/ready port; drops on overflow are counted.
module dmem_write_monitor #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       En,
  input  logic [ADDR_W-1:0]          AddrLo,
  input  logic [ADDR_W-1:0]          AddrHi,
  input  logic                       ClrOvf,
  dmem_write_monitor_if.slave        bus,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow,
  output logic [CNT_W-1:0]           DropCnt
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [TS_W-1:0]   r_ts_cnt;
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [TS_W-1:0]   r_mem_ts   [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];

  logic              w_cap;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [PTR_W:0]    w_count;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_rd_idx;

  always_comb begin
    w_cap    = En && bus.We && (bus.WrAddr >= AddrLo) && (bus.WrAddr <= AddrHi);
    w_count  = r_wr_ptr - r_rd_ptr;
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
               (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    w_pop    = !w_empty && bus.OutReady;
    // A pop frees the slot the same edge, so a full FIFO can still accept.
    w_push   = w_cap && (!w_full || w_pop);
    w_drop   = w_cap && w_full && !w_pop;
    w_wr_idx = r_wr_ptr[PTR_W-1:0];
    w_rd_idx = r_rd_ptr[PTR_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ts_cnt   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (ClrOvf) begin
        r_overflow <= w_drop;
        r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem_ts[w_wr_idx]   <= r_ts_cnt;
      r_mem_addr[w_wr_idx] <= bus.WrAddr;
      r_mem_data[w_wr_idx] <= bus.WrData;
    end
  end

  always_comb begin
    bus.OutValid = !w_empty;
    bus.OutTs    = r_mem_ts[w_rd_idx];
    bus.OutAddr  = r_mem_addr[w_rd_idx];
    bus.OutData  = r_mem_data[w_rd_idx];
    Count        = w_count;
    Overflow     = r_overflow;
    DropCnt      = r_drop_cnt;
  end
endmodule

// File: tb/tb_dmem_write_monitor.sv
// Directed self-checking bench for dmem_write_monitor.
module tb_dmem_write_monitor;
  logic        clk;
  logic        rst;
  logic        en;
  logic [14:0] addr_lo;
  logic [14:0] addr_hi;
  logic        clr_ovf;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned edge_n;
  int unsigned ts0;

  dmem_write_monitor_if #(.ADDR_W(15), .DATA_W(16), .TS_W(32)) bus ();

  dmem_write_monitor #(
    .ADDR_W(15), .DATA_W(16), .TS_W(32), .DEPTH(16), .CNT_W(16)
  ) dut (
    .Clk     (clk),
    .Reset   (rst),
    .En      (en),
    .AddrLo  (addr_lo),
    .AddrHi  (addr_hi),
    .ClrOvf  (clr_ovf),
    .bus     (bus.slave),
    .Count   (count),
    .Overflow(overflow),
    .DropCnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; edge_n holds the timestamp the next edge will use.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    bus.We = 1'b1; bus.WrAddr = a; bus.WrData = d;
    tick();
    bus.We = 1'b0;
  endtask

  task automatic pop();
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; edge_n = 0;
    en = 1'b0; addr_lo = '0; addr_hi = '0; clr_ovf = 1'b0;
    bus.We = 1'b0; bus.WrAddr = '0; bus.WrData = '0; bus.OutReady = 1'b0;

    // T1 reset / idle
    do_reset();
    check("t1_valid", bus.OutValid, 0);
    check("t1_count", count, 0);
    check("t1_ovf", overflow, 0);
    check("t1_drop", drop_cnt, 0);

    // T2 single capture at TsCnt=7 (edges 0..6 idle)
    en = 1'b1; addr_lo = 15'h0000; addr_hi = 15'h7FFF;
    repeat (7) tick();
    bus.We = 1'b1; bus.WrAddr = 15'h0010; bus.WrData = 16'hBEEF;
    #1 check("t2_no_comb_path", bus.OutValid, 0);
    tick();
    bus.We = 1'b0;
    check("t2_valid", bus.OutValid, 1);
    check("t2_ts", bus.OutTs, 7);
    check("t2_addr", bus.OutAddr, 15'h0010);
    check("t2_data", bus.OutData, 16'hBEEF);
    check("t2_count", count, 1);
    tick();
    check("t2_stable_data", bus.OutData, 16'hBEEF);
    pop();
    check("t2_drained", count, 0);

    // T3 window filter
    addr_lo = 15'h4000; addr_hi = 15'h5FFF;
    ts0 = edge_n;
    wr(15'h3FFF, 16'h0001);
    wr(15'h4000, 16'h0002);
    wr(15'h5FFF, 16'h0003);
    wr(15'h6000, 16'h0004);
    check("t3_count", count, 2);
    check("t3_drop", drop_cnt, 0);
    check("t3_addr0", bus.OutAddr, 15'h4000);
    check("t3_data0", bus.OutData, 16'h0002);
    check("t3_ts0", bus.OutTs, ts0 + 1);
    pop();
    check("t3_addr1", bus.OutAddr, 15'h5FFF);
    check("t3_ts1", bus.OutTs, ts0 + 2);
    pop();
    check("t3_empty", bus.OutValid, 0);

    // Empty window and En=0 capture nothing and drop nothing
    addr_lo = 15'h0010; addr_hi = 15'h0005;
    wr(15'h0007, 16'h1111);
    check("win_empty_count", count, 0);
    addr_lo = 15'h0000; addr_hi = 15'h7FFF; en = 1'b0;
    wr(15'h0007, 16'h2222);
    check("en_off_count", count, 0);
    check("en_off_drop", drop_cnt, 0);
    en = 1'b1;

    // T4 overflow: 20 writes into 16 slots
    ts0 = edge_n;
    for (int i = 0; i < 20; i++) wr(15'(i), 16'(16'h0100 + i));
    check("t4_count", count, 16);
    check("t4_ovf", overflow, 1);
    check("t4_drop", drop_cnt, 4);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_addr%0d", i), bus.OutAddr, i);
      check($sformatf("t4_data%0d", i), bus.OutData, 16'h0100 + i);
      check($sformatf("t4_ts%0d", i), bus.OutTs, ts0 + i);
      pop();
    end
    check("t4_drained", bus.OutValid, 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t4_clr_ovf", overflow, 0);
    check("t4_clr_drop", drop_cnt, 0);

    // T5 full + simultaneous pop
    for (int i = 0; i < 16; i++) wr(15'(16'h0200 + i), 16'(i));
    check("t5_full", count, 16);
    bus.OutReady = 1'b1;
    wr(15'h0300, 16'hCAFE);
    bus.OutReady = 1'b0;
    check("t5_count", count, 16);
    check("t5_drop", drop_cnt, 0);
    check("t5_ovf", overflow, 0);
    check("t5_head", bus.OutAddr, 15'h0201);
    // Two drops, then a drop coincident with clear leaves exactly one
    wr(15'h0400, 16'h0);
    wr(15'h0401, 16'h0);
    check("t5_drop2", drop_cnt, 2);
    clr_ovf = 1'b1;
    wr(15'h0402, 16'h0);
    clr_ovf = 1'b0;
    check("clr_drop_same_ovf", overflow, 1);
    check("clr_drop_same_cnt", drop_cnt, 1);
    for (int i = 0; i < 15; i++) pop();
    check("t5_tail_addr", bus.OutAddr, 15'h0300);
    check("t5_tail_data", bus.OutData, 16'hCAFE);
    check("t5_tail_count", count, 1);
    pop();

    // T6 asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) wr(15'(16'h0500 + i), 16'(i));
    check("t6_count5", count, 5);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", bus.OutValid, 0);
    check("t6_async_count", count, 0);
    check("t6_async_drop", drop_cnt, 0);
    #2 rst = 1'b0;
    edge_n = 0;
    wr(15'h0600, 16'h5A5A);
    check("t6_post_ts", bus.OutTs, 0);
    check("t6_post_addr", bus.OutAddr, 15'h0600);
    check("t6_post_count", count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
